// File: rtl/mem_access_unit.sv
// Load/store access unit: turns byte-addressed requests into word-aligned memory
// accesses, splitting boundary-crossing accesses over two cycles and aligning loads.
module mem_access_unit #(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned WORD_AW = DM_ADDRESS - 2;

  typedef enum logic {IDLE, SECOND} state_t;

  state_t state, state_nxt;

  // Access size in bytes from funct3[1:0]; 11 behaves as a word.
  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] sz);
    case (sz)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] d,
                                               input logic [2:0] sz,
                                               input logic sgn);
    case (sz)
      3'd1:    return {{(DATA_W-8){sgn & d[7]}}, d[7:0]};
      3'd2:    return {{(DATA_W-16){sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  logic [2:0] req_size;
  logic [3:0] req_mask;
  logic [1:0] off;
  logic [4:0] sh_first;
  logic       split;
  logic       active;
  logic       op_read;
  logic       op_write;

  logic               lat_read;
  logic               lat_write;
  logic [2:0]         lat_size;
  logic               lat_sign;
  logic [1:0]         lat_off;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  lat_low;
  logic [WORD_AW-1:0] lat_word;

  logic [2:0] inv;
  logic [5:0] sh_second;

  logic              take_split;
  logic              resp_valid_nxt;
  logic [DATA_W-1:0] resp_rdata_nxt;

  // Request decode; a load wins over a simultaneous store.
  always_comb begin
    req_size  = size_of(req_funct3[1:0]);
    req_mask  = mask_of(req_size);
    off       = req_addr[1:0];
    sh_first  = {off, 3'b000};
    split     = (4'(req_size) + 4'(off)) > 4'd4;
    active    = req_valid & (req_read | req_write);
    op_read   = req_read;
    op_write  = req_write & ~req_read;
    inv       = 3'd4 - {1'b0, lat_off};
    sh_second = {inv, 3'b000};
  end

  // Next state, memory-side drive and load assembly.
  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_be         = 4'b0000;
    mem_wdata      = '0;
    take_split     = 1'b0;
    resp_valid_nxt = 1'b0;
    resp_rdata_nxt = resp_rdata;
    case (state)
      IDLE: begin
        if (active) begin
          mem_addr  = {req_addr[DM_ADDRESS-1:2], 2'b00};
          mem_be    = 4'({4'b0000, req_mask} << off);
          mem_wdata = req_wdata << sh_first;
          mem_we    = op_write;
          if (split) begin
            stall      = 1'b1;
            take_split = 1'b1;
            state_nxt  = SECOND;
          end else if (op_read) begin
            resp_valid_nxt = 1'b1;
            resp_rdata_nxt = extend(mem_rdata >> sh_first, req_size, ~req_funct3[2]);
          end
        end
      end
      SECOND: begin
        mem_addr  = {lat_word + WORD_AW'(1), 2'b00};
        mem_be    = mask_of(lat_size) >> inv;
        mem_wdata = lat_wdata >> sh_second;
        mem_we    = lat_write;
        state_nxt = IDLE;
        if (lat_read) begin
          resp_valid_nxt = 1'b1;
          resp_rdata_nxt = extend(lat_low | (mem_rdata << sh_second), lat_size, lat_sign);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, response and split-context registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      lat_read   <= 1'b0;
      lat_write  <= 1'b0;
      lat_size   <= 3'd0;
      lat_sign   <= 1'b0;
      lat_off    <= 2'd0;
      lat_wdata  <= '0;
      lat_low    <= '0;
      lat_word   <= '0;
    end else begin
      state      <= state_nxt;
      resp_valid <= resp_valid_nxt;
      resp_rdata <= resp_rdata_nxt;
      if (take_split) begin
        lat_read  <= op_read;
        lat_write <= op_write;
        lat_size  <= req_size;
        lat_sign  <= ~req_funct3[2];
        lat_off   <= off;
        lat_wdata <= req_wdata;
        lat_low   <= mem_rdata >> sh_first;
        lat_word  <= req_addr[DM_ADDRESS-1:2];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random loads/stores
// checked against a byte-array memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_read = 1'b0;
  logic        req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [8:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-organised data memory attached to the unit.
  logic [31:0] tmem [0:127];
  assign mem_rdata = tmem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) tmem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Reference: flat byte-addressed memory.
  logic [7:0] ref_mem [0:511];

  int total = 0;
  int bad = 0;

  logic [8:0]  c1_addr, c2_addr;
  logic [3:0]  c1_be, c2_be;
  logic [31:0] c1_wd, c2_wd;
  logic        c1_we, c2_we;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [8:0] addr, input logic [2:0] f3);
    int n = nbytes(f3);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(int'(addr) + i) % 512];
    if (n < 4 && !f3[2] && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic ref_store(input logic [8:0] addr, input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) ref_mem[(int'(addr) + i) % 512] = wd[8*i +: 8];
  endtask

  // One request driven at a falling edge; returns at the falling edge where the
  // response is due, with the request dropped.
  task automatic do_req(input logic rd, input logic wr, input logic [8:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3);
    int n = nbytes(f3);
    logic spl = (int'(addr[1:0]) + n) > 4;
    logic is_load = rd;
    logic is_store = wr & ~rd;
    logic [31:0] exp_data = ref_load(addr, f3);
    logic [8:0] word0 = {addr[8:2], 2'b00};
    logic [8:0] word1 = word0 + 9'd4;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = addr; req_wdata = wd; req_funct3 = f3;
    #1;
    c1_addr = mem_addr; c1_be = mem_be; c1_wd = mem_wdata; c1_we = mem_we;
    check("stall_first", 32'(stall), 32'(spl));
    check("addr_first", 32'(c1_addr), 32'(word0));
    check("we_first", 32'(c1_we), 32'(is_store));
    @(posedge clk); @(negedge clk);
    if (spl) begin
      c2_addr = mem_addr; c2_be = mem_be; c2_wd = mem_wdata; c2_we = mem_we;
      check("stall_second", 32'(stall), 32'd0);
      check("addr_second", 32'(c2_addr), 32'(word1));
      check("we_second", 32'(c2_we), 32'(is_store));
      check("resp_gap", 32'(resp_valid), 32'd0);
      @(posedge clk); @(negedge clk);
    end
    check("resp_valid", 32'(resp_valid), 32'(is_load));
    if (is_load) begin
      check("resp_data", resp_rdata, exp_data);
      last_rdata = resp_rdata;
    end
    if (is_store) ref_store(addr, wd, n);
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] a;
    logic [2:0] f;
    logic [31:0] d;
    int op;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
    for (int w = 0; w < 128; w++)
      for (int b = 0; b < 4; b++) tmem[w][8*b +: 8] = ref_mem[4*w + b];

    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned word round trip
    do_req(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010);
    check("sw_be", 32'(c1_be), 32'hF);
    check("sw_wd", c1_wd, 32'hDEADBEEF);
    do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    check("lw_word", last_rdata, 32'hDEADBEEF);

    // Byte and half extension
    do_req(1'b1, 1'b0, 9'h013, 32'h0, 3'b000);
    check("lb", last_rdata, 32'hFFFFFFDE);
    do_req(1'b1, 1'b0, 9'h013, 32'h0, 3'b100);
    check("lbu", last_rdata, 32'h000000DE);
    do_req(1'b1, 1'b0, 9'h012, 32'h0, 3'b001);
    check("lh", last_rdata, 32'hFFFFDEAD);
    do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b101);
    check("lhu", last_rdata, 32'h0000BEEF);
    do_req(1'b0, 1'b1, 9'h011, 32'h00000055, 3'b000);
    check("sb_be", 32'(c1_be), 32'h2);
    check("sb_wd", c1_wd, 32'h00005500);

    // Split store then load
    do_req(1'b0, 1'b1, 9'h00E, 32'h11223344, 3'b010);
    check("ssw_addr1", 32'(c1_addr), 32'h00C);
    check("ssw_be1", 32'(c1_be), 32'hC);
    check("ssw_wd1", c1_wd, 32'h33440000);
    check("ssw_addr2", 32'(c2_addr), 32'h010);
    check("ssw_be2", 32'(c2_be), 32'h3);
    check("ssw_wd2", c2_wd, 32'h00001122);
    do_req(1'b1, 1'b0, 9'h00E, 32'h0, 3'b010);
    check("slw", last_rdata, 32'h11223344);

    // Address wrap
    do_req(1'b0, 1'b1, 9'h1FF, 32'h0000A5C3, 3'b001);
    check("wrap_addr1", 32'(c1_addr), 32'h1FC);
    check("wrap_be1", 32'(c1_be), 32'h8);
    check("wrap_addr2", 32'(c2_addr), 32'h000);
    check("wrap_be2", 32'(c2_be), 32'h1);
    do_req(1'b1, 1'b0, 9'h1FF, 32'h0, 3'b101);
    check("wrap_lhu", last_rdata, 32'h0000A5C3);

    // Read and write both high: load only
    do_req(1'b1, 1'b1, 9'h010, 32'h12345678, 3'b010);
    check("rw_we", 32'(c1_we), 32'd0);

    // Reset during the second half of a split store
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
    req_addr = 9'h00D; req_wdata = 32'hCAFEF00D; req_funct3 = 3'b010;
    #1;
    check("rsplit_stall", 32'(stall), 32'd1);
    @(posedge clk); @(negedge clk);
    ref_store(9'h00D, 32'hCAFEF00D, 3);
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    #1;
    check("rsplit_we", 32'(mem_we), 32'd0);
    check("rsplit_stall0", 32'(stall), 32'd0);
    check("rsplit_resp", 32'(resp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    check("rsplit_we_held", 32'(mem_we), 32'd0);
    check("rsplit_addr", 32'(mem_addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rsplit_idle_resp", 32'(resp_valid), 32'd0);
    do_req(1'b1, 1'b0, 9'h010, 32'h0, 3'b010);
    do_req(1'b1, 1'b0, 9'h00C, 32'h0, 3'b010);

    // Random traffic, including idle cycles and back-to-back requests
    for (int k = 0; k < 400; k++) begin
      a = 9'($urandom);
      f = 3'($urandom_range(0, 7));
      d = $urandom;
      op = $urandom_range(0, 4);
      case (op)
        0, 1: do_req(1'b1, 1'b0, a, d, f);
        2, 3: do_req(1'b0, 1'b1, a, d, f);
        default: begin
          req_valid = 1'b0; req_read = 1'b1; req_write = 1'b1; req_addr = a;
          #1;
          check("idle_we", 32'(mem_we), 32'd0);
          check("idle_be", 32'(mem_be), 32'd0);
          check("idle_stall", 32'(stall), 32'd0);
          @(posedge clk); @(negedge clk);
          check("idle_resp", 32'(resp_valid), 32'd0);
          req_read = 1'b0; req_write = 1'b0;
        end
      endcase
    end

    // Final sweep of memory contents through loads
    for (int w = 0; w < 128; w++) do_req(1'b1, 1'b0, 9'(4 * w), 32'h0, 3'b010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
